// File: rtl/cluster_task_scheduler.sv
// Dispatches MPQ handler tasks to the least-occupied cluster with a free HER slot.
// Define PSPIN_SCHED_RR_TIE_EN to break equal-occupancy ties with a round-robin pointer.
module cluster_task_scheduler #(
    parameter  int NUM_CLUSTERS = 4,
    parameter  int CLUSTER_CAP  = 20,
    parameter  int TASK_W       = 32,
    localparam int OCC_W        = $clog2(CLUSTER_CAP + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          task_valid_i,
    output logic                          task_ready_o,
    input  logic [TASK_W-1:0]             task_i,
    output logic [NUM_CLUSTERS-1:0]       cluster_valid_o,
    input  logic [NUM_CLUSTERS-1:0]       cluster_ready_i,
    output logic [TASK_W-1:0]             cluster_task_o,
    input  logic [NUM_CLUSTERS-1:0]       feedback_i,
    output logic [NUM_CLUSTERS*OCC_W-1:0] occup_o,
    output logic                          err_o
);
    localparam int TGT_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PICK  = 2'd1,
        OFFER = 2'd2
    } state_e;

    state_e                  r_state, w_state_nxt;
    logic [TASK_W-1:0]       r_task;
    logic [TGT_W-1:0]        r_tgt;
    logic [OCC_W-1:0]        r_occ     [NUM_CLUSTERS];
    logic [OCC_W-1:0]        w_occ_fb  [NUM_CLUSTERS];
    logic [OCC_W-1:0]        w_occ_nxt [NUM_CLUSTERS];
    logic [NUM_CLUSTERS-1:0] w_reserve;
    logic [NUM_CLUSTERS-1:0] w_underflow;
    logic                    r_err;
    logic                    w_found;
    logic [TGT_W-1:0]        w_sel;
    logic [OCC_W-1:0]        w_best;
    logic [TGT_W-1:0]        w_idx;
    logic                    w_pick;
    logic                    w_handshake;
`ifdef PSPIN_SCHED_RR_TIE_EN
    logic [TGT_W-1:0]        r_rr_ptr;
    logic [TGT_W:0]          w_sum;
`endif

    // Candidacy looks at occupancy after this cycle's feedback, so a full stall clears on the feedback cycle.
    always_comb begin
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            w_occ_fb[i] = r_occ[i] - OCC_W'(feedback_i[i] && (r_occ[i] != '0));
        end
    end

    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_best  = '0;
        w_idx   = '0;
`ifdef PSPIN_SCHED_RR_TIE_EN
        w_sum   = '0;
`endif
        for (int k = 0; k < NUM_CLUSTERS; k++) begin
`ifdef PSPIN_SCHED_RR_TIE_EN
            w_sum = {1'b0, r_rr_ptr} + (TGT_W+1)'(k);
            w_idx = (w_sum >= (TGT_W+1)'(NUM_CLUSTERS)) ? TGT_W'(w_sum - (TGT_W+1)'(NUM_CLUSTERS))
                                                        : TGT_W'(w_sum);
`else
            w_idx = TGT_W'(k);
`endif
            // Strict less-than keeps the first candidate in scan order on ties.
            if ((w_occ_fb[w_idx] < OCC_W'(CLUSTER_CAP)) && (!w_found || (w_occ_fb[w_idx] < w_best))) begin
                w_found = 1'b1;
                w_sel   = w_idx;
                w_best  = w_occ_fb[w_idx];
            end
        end
    end

    assign w_pick      = (r_state == PICK) && w_found;
    assign w_handshake = (r_state == OFFER) && cluster_ready_i[r_tgt];

    always_comb begin
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            w_reserve[i]   = w_pick && (w_sel == TGT_W'(i));
            w_underflow[i] = feedback_i[i] && (r_occ[i] == '0) && !w_reserve[i];
            w_occ_nxt[i]   = r_occ[i] + OCC_W'(w_reserve[i]);
            w_occ_nxt[i]   = w_occ_nxt[i] - OCC_W'(feedback_i[i] && (w_occ_nxt[i] != '0));
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        task_ready_o    = 1'b0;
        cluster_valid_o = '0;
        case (r_state)
            IDLE: begin
                task_ready_o = 1'b1;
                if (task_valid_i) w_state_nxt = PICK;
            end
            PICK: begin
                if (w_found) w_state_nxt = OFFER;
            end
            OFFER: begin
                cluster_valid_o[r_tgt] = 1'b1;
                if (cluster_ready_i[r_tgt]) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_task  <= '0;
            r_tgt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && task_valid_i) r_task <= task_i;
            if (w_pick) r_tgt <= w_sel;
            if (|w_underflow) r_err <= 1'b1;
        end
    end

    // NOTE: the counter array is small and architecturally visible, so it is reset, unlike a RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CLUSTERS; i++) r_occ[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CLUSTERS; i++) r_occ[i] <= w_occ_nxt[i];
        end
    end

`ifdef PSPIN_SCHED_RR_TIE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_handshake) begin
            r_rr_ptr <= (r_tgt == TGT_W'(NUM_CLUSTERS - 1)) ? '0 : r_tgt + 1'b1;
        end
    end
`endif

    always_comb begin
        occup_o = '0;
        for (int i = 0; i < NUM_CLUSTERS; i++) occup_o[i*OCC_W +: OCC_W] = r_occ[i];
    end

    assign cluster_task_o = r_task;
    assign err_o          = r_err;

endmodule

// File: tb/tb_cluster_task_scheduler.sv
// Self-checking bench for cluster_task_scheduler: vector table plus scoreboard of dispatched tasks.
// Expected targets follow PSPIN_SCHED_RR_TIE_EN when it is defined for the build.
module tb_cluster_task_scheduler;
    localparam int NC     = 4;
    localparam int CAP    = 20;
    localparam int TW     = 32;
    localparam int OW     = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            task_valid_i;
    logic            task_ready_o;
    logic [TW-1:0]   task_i;
    logic [NC-1:0]   cluster_valid_o;
    logic [NC-1:0]   cluster_ready_i;
    logic [TW-1:0]   cluster_task_o;
    logic [NC-1:0]   feedback_i;
    logic [NC*OW-1:0] occup_o;
    logic            err_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [TW-1:0]    payload;
        logic [NC-1:0]    fb_pick;
        int               exp_tgt;
        logic [NC*OW-1:0] exp_occ;
    } vec_t;

    typedef struct {
        logic [TW-1:0] payload;
        int            tgt;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[6];

    cluster_task_scheduler #(
        .NUM_CLUSTERS(NC),
        .CLUSTER_CAP (CAP),
        .TASK_W      (TW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .task_valid_i   (task_valid_i),
        .task_ready_o   (task_ready_o),
        .task_i         (task_i),
        .cluster_valid_o(cluster_valid_o),
        .cluster_ready_i(cluster_ready_i),
        .cluster_task_o (cluster_task_o),
        .feedback_i     (feedback_i),
        .occup_o        (occup_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [NC*OW-1:0] occ4(input int a, input int b, input int c, input int d);
        return {OW'(d), OW'(c), OW'(b), OW'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        task_valid_i = 1'b0; task_i = '0; cluster_ready_i = '0; feedback_i = '0;
        repeat (2) cyc();
        rst_ni = 1'b1;
        cyc();
    endtask

    // Issues one task from IDLE, applies fb_pick during PICK, accepts on the cluster side.
    task automatic dispatch(input logic [TW-1:0] pl, input logic [NC-1:0] fb_pick, input int exp_tgt);
        int            lat;
        sb_t           e;
        logic [NC-1:0] oh;
        task_valid_i = 1'b1;
        task_i       = pl;
        sb_q.push_back('{payload: pl, tgt: exp_tgt});
        cyc();
        task_valid_i = 1'b0;
        feedback_i   = fb_pick;
        lat = 1;
        cyc();
        feedback_i = '0;
        lat = 2;
        while (cluster_valid_o == '0 && lat < 50) begin
            cyc();
            lat++;
        end
        check("valid_latency", 64'(lat), 64'd2);
        e  = sb_q.pop_front();
        oh = 4'b0001 << e.tgt;
        check("target_onehot", 64'(cluster_valid_o), 64'(oh));
        check("task_payload", 64'(cluster_task_o), 64'(e.payload));
        cluster_ready_i = cluster_valid_o;
        cyc();
        cluster_ready_i = '0;
    endtask

    initial begin
        logic [NC-1:0] v0;
        logic [TW-1:0] t0;
        int            exp;

        vecs[0] = '{32'hA000_0000, 4'b0000, 0, occ4(1, 0, 0, 0)};
        vecs[1] = '{32'hA000_0001, 4'b0000, 1, occ4(1, 1, 0, 0)};
        vecs[2] = '{32'hA000_0002, 4'b0000, 2, occ4(1, 1, 1, 0)};
        vecs[3] = '{32'hA000_0003, 4'b0000, 3, occ4(1, 1, 1, 1)};
        vecs[4] = '{32'hB000_0004, 4'b0000, 0, occ4(2, 1, 1, 1)};
        vecs[5] = '{32'hC000_0005, 4'b0010, 1, occ4(2, 1, 1, 1)};

        do_reset();
        check("rst_task_ready", 64'(task_ready_o), 64'd1);
        check("rst_cluster_valid", 64'(cluster_valid_o), 64'd0);
        check("rst_cluster_task", 64'(cluster_task_o), 64'd0);
        check("rst_occup", 64'(occup_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);

        // Four fresh tasks spread one per cluster; then a same-cycle reserve/feedback on cluster 1.
        for (int i = 0; i < 6; i++) begin
            dispatch(vecs[i].payload, vecs[i].fb_pick, vecs[i].exp_tgt);
            check("vec_occup", 64'(occup_o), 64'(vecs[i].exp_occ));
            check("vec_err", 64'(err_o), 64'd0);
        end

        // Underflow on cluster 3.
        feedback_i = 4'b1000; cyc(); feedback_i = '0;
        check("fb_to_zero_occup", 64'(occup_o), 64'(occ4(2, 1, 1, 0)));
        check("fb_to_zero_err", 64'(err_o), 64'd0);
        feedback_i = 4'b1000; cyc(); feedback_i = '0;
        check("underflow_occup", 64'(occup_o), 64'(occ4(2, 1, 1, 0)));
        check("underflow_err", 64'(err_o), 64'd1);
        repeat (3) cyc();
        check("underflow_err_sticky", 64'(err_o), 64'd1);
        do_reset();
        check("err_cleared_by_reset", 64'(err_o), 64'd0);

        // Fill every cluster to capacity, then stall a task in PICK until feedback frees cluster 2.
        for (int k = 0; k < NC * CAP; k++) dispatch(32'h1000_0000 + 32'(k), 4'b0000, k % NC);
        check("full_occup", 64'(occup_o), 64'(occ4(CAP, CAP, CAP, CAP)));
        task_valid_i = 1'b1; task_i = 32'hDEAD_BEEF;
        cyc();
        task_valid_i = 1'b0;
        repeat (4) cyc();
        check("stall_task_ready", 64'(task_ready_o), 64'd0);
        check("stall_cluster_valid", 64'(cluster_valid_o), 64'd0);
        feedback_i = 4'b0100; cyc(); feedback_i = '0;
        check("stall_exit_target", 64'(cluster_valid_o), 64'b0100);
        check("stall_exit_payload", 64'(cluster_task_o), 64'hDEAD_BEEF);
        check("stall_exit_occup", 64'(occup_o), 64'(occ4(CAP, CAP, CAP, CAP)));
        check("stall_exit_err", 64'(err_o), 64'd0);
        cluster_ready_i = 4'b0100; cyc(); cluster_ready_i = '0;
        check("stall_done_ready", 64'(task_ready_o), 64'd1);

        // Offer held without ready, then reset lands in the third held cycle.
        do_reset();
        task_valid_i = 1'b1; task_i = 32'h5A5A_1234;
        cyc();
        task_valid_i = 1'b0;
        cyc();
        v0 = cluster_valid_o;
        t0 = cluster_task_o;
        check("hold_first_valid", 64'(v0), 64'b0001);
        check("hold_first_payload", 64'(t0), 64'h5A5A_1234);
        check("hold_first_occup", 64'(occup_o), 64'(occ4(1, 0, 0, 0)));
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin
                rst_ni = 1'b0;
                #1;
                check("async_rst_valid", 64'(cluster_valid_o), 64'd0);
                check("async_rst_task", 64'(cluster_task_o), 64'd0);
                check("async_rst_ready", 64'(task_ready_o), 64'd1);
                check("async_rst_occup", 64'(occup_o), 64'd0);
                check("async_rst_err", 64'(err_o), 64'd0);
                break;
            end
            cyc();
            check("hold_valid_stable", 64'(cluster_valid_o), 64'(v0));
            check("hold_task_stable", 64'(cluster_task_o), 64'(t0));
        end
        cyc();
        rst_ni = 1'b1;
        cyc();

        // Balanced load: each dispatch is returned by feedback, so only the tie-break decides.
        do_reset();
        for (int k = 0; k < 5; k++) begin
`ifdef PSPIN_SCHED_RR_TIE_EN
            exp = k % NC;
`else
            exp = 0;
`endif
            dispatch(32'h7700_0000 + 32'(k), 4'b0000, exp);
            feedback_i = 4'b0001 << exp;
            cyc();
            feedback_i = '0;
            check("balanced_occup", 64'(occup_o), 64'd0);
        end
        check("balanced_err", 64'(err_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
